// File: rtl/shift_sub_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_sub_divider_pkg
// Purpose  : Shared definitions for the shift-subtract divider: FSM state
//            encoding, default operand width and the iteration-counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package shift_sub_divider_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

   // The counter must hold the value WIDTH itself, hence WIDTH+1.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

   localparam int unsigned CNT_W = $clog2(DEFAULT_WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/shift_sub_divider_control.sv
`default_nettype none
// ============================================================================
// Module   : div_control
// Purpose  : Sequencer for the shift-subtract divider. Holds the IDLE/RUN/DONE
//            state and the iteration counter and issues datapath strobes.
// Ports    : clk_i          - clock
//            rst_ni         - synchronous active-low reset
//            start_i        - operation request (honoured only in IDLE)
//            divisor_zero_i - current divisor input is zero
//            load_o         - latch operands, start iterating
//            step_o         - perform one shift/subtract iteration
//            finish_o       - current iteration is the last one
//            div0_o         - divide-by-zero completion
//            busy_o         - registered, high in RUN and DONE
//            done_o         - registered one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module div_control
   import shift_sub_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start_i,
   input  logic divisor_zero_i,
   output logic load_o,
   output logic step_o,
   output logic finish_o,
   output logic div0_o,
   output logic busy_o,
   output logic done_o
);

   localparam int unsigned CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            busy_q;
   logic            done_q;

   assign load_o   = (state_q == ST_IDLE) && start_i && !divisor_zero_i;
   assign div0_o   = (state_q == ST_IDLE) && start_i &&  divisor_zero_i;
   assign step_o   = (state_q == ST_RUN);
   // Counter still reads 1 while the final iteration is being performed.
   assign finish_o = step_o && (cnt_q == CNT_ONE);

   assign busy_o = busy_q;
   assign done_o = done_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (load_o) begin
                  state_q <= ST_RUN;
                  cnt_q   <= CNT_LOAD;
                  busy_q  <= 1'b1;
               end else if (div0_o) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               cnt_q <= cnt_q - CNT_ONE;
               if (finish_o) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/shift_sub_divider.sv
`default_nettype none
// ============================================================================
// Module   : shift_sub_divider
// Purpose  : Sequential unsigned restoring divider, one quotient bit per clock.
// Ports    : clk_i          - clock
//            rst_ni         - synchronous active-low reset
//            start_i        - start request, sampled in IDLE
//            dividend_i     - unsigned dividend, sampled with start_i
//            divisor_i      - unsigned divisor, sampled with start_i
//            quotient_o     - registered quotient
//            remainder_o    - registered remainder
//            busy_o         - high while an operation is in RUN or DONE
//            done_o         - one-cycle pulse, results valid
//            div_by_zero_o  - last operation had a zero divisor
// Revision : 1.0 - initial release
// ============================================================================
module shift_sub_divider
   import shift_sub_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_by_zero_o
);

   logic load_w;
   logic step_w;
   logic finish_w;
   logic div0_w;

   // Partial remainder is stored in WIDTH bits: after every iteration it is
   // strictly below the divisor, so the top bit of the WIDTH+1 bit working
   // value is always zero and only matters inside the compare/subtract.
   logic [WIDTH-1:0] r_work_q, r_work_d;
   logic [WIDTH-1:0] q_work_q, q_work_d;
   logic [WIDTH-1:0] d_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             dbz_q;

   logic [WIDTH:0]   trial_w;
   logic [WIDTH:0]   diff_w;
   logic             qbit_w;

   div_control #(
      .WIDTH (WIDTH)
   ) u_ctrl (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .start_i        (start_i),
      .divisor_zero_i (divisor_i == '0),
      .load_o         (load_w),
      .step_o         (step_w),
      .finish_o       (finish_w),
      .div0_o         (div0_w),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   // One restoring-division iteration: shift in the next dividend bit and
   // subtract the divisor when it fits.
   always_comb begin
      trial_w  = {r_work_q, q_work_q[WIDTH-1]};
      diff_w   = trial_w - {1'b0, d_q};
      qbit_w   = (trial_w >= {1'b0, d_q});
      r_work_d = qbit_w ? diff_w[WIDTH-1:0] : trial_w[WIDTH-1:0];
      q_work_d = {q_work_q[WIDTH-2:0], qbit_w};
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_work_q    <= '0;
         q_work_q    <= '0;
         d_q         <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         if (load_w) begin
            q_work_q <= dividend_i;
            d_q      <= divisor_i;
            r_work_q <= '0;
         end else if (step_w) begin
            r_work_q <= r_work_d;
            q_work_q <= q_work_d;
         end

         // Results update only on entry to DONE.
         if (finish_w) begin
            quotient_q  <= q_work_d;
            remainder_q <= r_work_d;
            dbz_q       <= 1'b0;
         end else if (div0_w) begin
            quotient_q  <= '1;
            remainder_q <= dividend_i;
            dbz_q       <= 1'b1;
         end
      end
   end

   assign quotient_o    = quotient_q;
   assign remainder_o   = remainder_q;
   assign div_by_zero_o = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_sub_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sub_divider
// Purpose  : Self-checking bench for shift_sub_divider against an arithmetic
//            reference (A/B, A%B, divide-by-zero rule).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sub_divider;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         busy;
   logic         done;
   logic         dbz;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   shift_sub_divider #(.WIDTH(W)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .dividend_i    (dividend),
      .divisor_i     (divisor),
      .quotient_o    (quotient),
      .remainder_o   (remainder),
      .busy_o        (busy),
      .done_o        (done),
      .div_by_zero_o (dbz)
   );

   // Issue one operation, scramble the operands while busy, wait for Done
   // and compare with plain arithmetic.
   task automatic do_divide(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      logic [W-1:0] eq, er;
      logic         ez;
      int           elat;
      int           n;
      if (b == 0) begin
         eq = '1; er = a; ez = 1'b1; elat = 0;
      end else begin
         eq = a / b; er = a % b; ez = 1'b0; elat = W;
      end
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0; dividend = $urandom; divisor = $urandom;
      n = 0;
      while (!done && n < W + 8) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n !== elat) begin
         fails++;
         $display("FAIL %s latency: got %0d cycles, expected %0d (a=%0h b=%0h)", tag, n, elat, a, b);
      end
      tests++;
      if (quotient !== eq) begin
         fails++;
         $display("FAIL %s quotient: got %0h, expected %0h (a=%0h b=%0h)", tag, quotient, eq, a, b);
      end
      tests++;
      if (remainder !== er) begin
         fails++;
         $display("FAIL %s remainder: got %0h, expected %0h (a=%0h b=%0h)", tag, remainder, er, a, b);
      end
      tests++;
      if (dbz !== ez) begin
         fails++;
         $display("FAIL %s div_by_zero: got %0b, expected %0b (a=%0h b=%0h)", tag, dbz, ez, a, b);
      end
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL %s busy_at_done: got %0b, expected 1", tag, busy);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL %s after_done: got done=%0b busy=%0b, expected 0/0", tag, done, busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      tests++;
      if (quotient !== '0) begin fails++; $display("FAIL reset quotient: got %0h, expected 0", quotient); end
      tests++;
      if (remainder !== '0) begin fails++; $display("FAIL reset remainder: got %0h, expected 0", remainder); end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %0b, expected 0", busy); end
      tests++;
      if (done !== 1'b0) begin fails++; $display("FAIL reset done: got %0b, expected 0", done); end
      tests++;
      if (dbz !== 1'b0) begin fails++; $display("FAIL reset div_by_zero: got %0b, expected 0", dbz); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      do_divide(32'd100, 32'd7, "d100_7");
      do_divide(32'd3, 32'd10, "d3_10");
      do_divide(32'd0, 32'd5, "d0_5");
      do_divide(32'hFFFF_FFFF, 32'd1, "dmax_1");
      do_divide(32'hFFFF_FFFF, 32'h8000_0000, "dmax_msb");
   endtask

   task automatic test_div_zero();
      do_divide(32'd5, 32'd0, "d5_0");
      do_divide(32'd9, 32'd3, "d9_3");
   endtask

   // Extra Starts at edges 5, 32 (last RUN step) and 33 (DONE) must be ignored.
   task automatic test_ignore_start();
      int pulses = 0;
      @(negedge clk);
      start = 1'b1; dividend = 32'd100; divisor = 32'd7;
      @(negedge clk);
      for (int cyc = 0; cyc < 40; cyc++) begin
         start = (cyc == 4 || cyc == 31 || cyc == 32);
         dividend = 32'd50; divisor = 32'd5;
         @(negedge clk);
         if (done) begin
            pulses++;
            tests++;
            if (cyc + 1 != W) begin
               fails++;
               $display("FAIL ignore_start done_edge: got edge %0d, expected %0d", cyc + 1, W);
            end
            tests++;
            if (quotient !== 32'd14 || remainder !== 32'd2) begin
               fails++;
               $display("FAIL ignore_start result: got %0d r %0d, expected 14 r 2", quotient, remainder);
            end
         end
      end
      start = 1'b0;
      tests++;
      if (pulses != 1) begin
         fails++;
         $display("FAIL ignore_start pulses: got %0d, expected 1", pulses);
      end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL ignore_start busy_end: got %0b, expected 0", busy);
      end
   endtask

   task automatic test_reset_abort();
      int pulses = 0;
      @(negedge clk);
      start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      tests++;
      if (quotient !== '0 || remainder !== '0 || busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0) begin
         fails++;
         $display("FAIL abort outputs: got q=%0h r=%0h busy=%0b done=%0b dbz=%0b, expected all 0",
                  quotient, remainder, busy, done, dbz);
      end
      rst_n = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (done) pulses++;
      end
      tests++;
      if (pulses != 0) begin
         fails++;
         $display("FAIL abort done_fired: got %0d pulses, expected 0", pulses);
      end
      do_divide(32'd1000, 32'd3, "d1000_3");
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      for (int i = 0; i < 1200; i++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = '0;
            1: b = a;
            2: b = W'($urandom_range(1, 15));
            3: a = W'($urandom_range(0, 255));
            4: b = b >> $urandom_range(0, 31);
            default: ;
         endcase
         do_divide(a, b, "rand");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_div_zero();
      test_ignore_start();
      test_reset_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
